regfile_2r1w_param: RTL and testbench
=====================================

REGFILE_2R1W_PARAM -- requirements
Module: regfile_2r1w_param

Interface
REQ-001 Parameter DATA_W, default 32, word width in bits (legal range 8..64).
REQ-002 Parameter DEPTH, default 32, register count (legal range 2..64; need not be a power of two).
REQ-003 Parameter ADDR_W, default $clog2(DEPTH), address width.
REQ-004 Port clk, input, 1, single clock; all state updates on its rising edge.
REQ-005 Port reset, input, 1, synchronous, active-high; clears all registers and busy bits.
REQ-006 Port S_Addr, input, ADDR_W, read port S address.
REQ-007 Port T_Addr, input, ADDR_W, read port T address.
REQ-008 Port D_Addr, input, ADDR_W, write address.
REQ-009 Port D, input, DATA_W, write data.
REQ-010 Port D_En, input, 1, write enable.
REQ-011 Port L_Addr, input, ADDR_W, lock address: marks the register as awaiting a pending write.
REQ-012 Port L_En, input, 1, lock enable.
REQ-013 Port S, output, DATA_W, read data for S_Addr.
REQ-014 Port T, output, DATA_W, read data for T_Addr.
REQ-015 Port S_Busy, output, 1, busy bit of S_Addr.
REQ-016 Port T_Busy, output, 1, busy bit of T_Addr.

Function
REQ-017 Write: when D_En=1 and reset=0, reg[D_Addr] <= D at the rising edge; takes effect the next cycle.
REQ-018 Reads are combinational, with zero-cycle latency from the address inputs to S and T.
REQ-019 Bypass: when D_En=1, reset=0 and D_Addr equals S_Addr (or T_Addr), S (or T) equals D in the same cycle.
REQ-020 The bypass is suppressed while reset=1, and S and T then show the stored contents.
REQ-021 Scoreboard: when L_En=1, busy[L_Addr] <= 1 at the rising edge.
REQ-022 Scoreboard: a write to D_Addr clears busy[D_Addr] <= 0 at the rising edge.
REQ-023 If a lock and a write target the same address in the same cycle, the lock wins and busy stays 1.
REQ-024 S_Busy and T_Busy are combinational from busy[] and reflect registered state only; the write-clear is not bypassed.
REQ-025 A write to a register whose busy bit is 0 is legal: the data is written and busy stays 0.
REQ-026 Addresses >= DEPTH: reads return 0 with busy 0; writes and locks to them are ignored.
REQ-027 S and T ports operate independently, and S_Addr = T_Addr is legal.

Reset
REQ-028 With reset=1 at an edge, all registers <= 0 and all busy bits <= 0, regardless of D_En or L_En.
REQ-029 After reset, S=0, T=0, S_Busy=0 and T_Busy=0 for every address.
REQ-030 A reset asserted while locks are outstanding discards them; no write is required to clear them.

Configuration
REQ-031 Macro REGFILE_R0_ZERO_EN, when defined, hardwires register 0 to zero.
REQ-032 With REGFILE_R0_ZERO_EN defined: writes and locks to address 0 are ignored, reads return 0, the bypass is disabled for address 0, and busy[0] is permanently 0.
REQ-033 With REGFILE_R0_ZERO_EN undefined, register 0 behaves like every other register.

Structure
REQ-034 Package regfile_pkg holds the default DATA_W and DEPTH constants, the addr_t and word_t typedefs, and the ADDR_W derivation function.
REQ-035 The busy-bit array and its lock/clear/priority logic live in sub-module regfile_scoreboard (parameter DEPTH), instantiated once.

Verification
REQ-036 Reset, then dump all 32 addresses on S and T (S_Addr=i, T_Addr=i+16) -> every read returns 0 and every busy bit is 0.
REQ-037 Write reg[i] = 32'hA5A50000+i for i=1..30, then dump -> S/T return the written values; with REGFILE_R0_ZERO_EN, reg0 reads 0 after a write of 32'hFFFFFFFF.
REQ-038 D_En=1, D_Addr=5, D=32'h12345678 and S_Addr=T_Addr=5 in the same cycle -> S=T=32'h12345678 in that cycle; repeating this with reset=1 -> S=T=old contents.
REQ-039 L_En on addr 7 in cycle n -> S_Busy=1 from n+1; write to 7 in cycle m -> S_Busy=0 from m+1; lock and write to 9 in the same cycle -> busy[9]=1 afterwards.
REQ-040 Lock addrs 3 and 4, then reset mid-operation -> both busy bits 0 and both registers 0 on the next cycle.
REQ-041 DEPTH=20: read addr 25 -> 0 with busy 0; write 32'hDEADBEEF to addr 25 -> no register changes.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared constants and types for the 2-read/1-write register file with busy scoreboard.
package regfile_pkg;

    localparam int DEFAULT_DATA_W = 32;
    localparam int DEFAULT_DEPTH  = 32;

    // Address width for a given register count; never narrower than one bit.
    function automatic int addr_w_of(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    typedef logic [DEFAULT_DATA_W-1:0]             word_t;
    typedef logic [addr_w_of(DEFAULT_DEPTH)-1:0]   addr_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy-bit array: lock sets, write clears, lock wins on a same-address collision.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int DEPTH  = DEFAULT_DEPTH,
    parameter int ADDR_W = addr_w_of(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              lock_en,
    input  logic [ADDR_W-1:0] lock_addr,
    input  logic              clr_en,
    input  logic [ADDR_W-1:0] clr_addr,
    input  logic [ADDR_W-1:0] rd_a_addr,
    input  logic [ADDR_W-1:0] rd_b_addr,
    output logic              rd_a_busy,
    output logic              rd_b_busy
);

    localparam logic [ADDR_W:0] DEPTH_L = DEPTH[ADDR_W:0];

    logic [DEPTH-1:0] busy_q;

    // Enables arrive already qualified for range; the lock is applied last so it wins.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q <= '0;
        end else begin
            if (clr_en)  busy_q[clr_addr]  <= 1'b0;
            if (lock_en) busy_q[lock_addr] <= 1'b1;
        end
    end

    assign rd_a_busy = ({1'b0, rd_a_addr} < DEPTH_L) ? busy_q[rd_a_addr] : 1'b0;
    assign rd_b_busy = ({1'b0, rd_b_addr} < DEPTH_L) ? busy_q[rd_b_addr] : 1'b0;

endmodule

// File: rtl/regfile_2r1w_param.sv
// Two combinational read ports, one write port with same-cycle bypass, plus busy scoreboard.
// Define REGFILE_R0_ZERO_EN to hardwire register 0 to zero (never written, locked or bypassed).
module regfile_2r1w_param
    import regfile_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int DEPTH  = DEFAULT_DEPTH,
    parameter int ADDR_W = addr_w_of(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] S_Addr,
    input  logic [ADDR_W-1:0] T_Addr,
    input  logic [ADDR_W-1:0] D_Addr,
    input  logic [DATA_W-1:0] D,
    input  logic              D_En,
    input  logic [ADDR_W-1:0] L_Addr,
    input  logic              L_En,
    output logic [DATA_W-1:0] S,
    output logic [DATA_W-1:0] T,
    output logic              S_Busy,
    output logic              T_Busy
);

    localparam logic [ADDR_W:0] DEPTH_L = DEPTH[ADDR_W:0];

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic              wr_ok;
    logic              lock_ok;
    logic              s_live;
    logic              t_live;

    // An address is "live" when it maps onto a real, writable register.
    function automatic logic live(input logic [ADDR_W-1:0] a);
        live = ({1'b0, a} < DEPTH_L);
`ifdef REGFILE_R0_ZERO_EN
        if (a == '0) live = 1'b0;
`endif
    endfunction

    assign wr_ok   = D_En && live(D_Addr);
    assign lock_ok = L_En && live(L_Addr);
    assign s_live  = live(S_Addr);
    assign t_live  = live(T_Addr);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
        end else if (wr_ok) begin
            regs_q[D_Addr] <= D;
        end
    end

    // Bypass is gated by reset so a reset cycle shows the stored contents.
    always_comb begin
        S = '0;
        T = '0;
        if (s_live) S = regs_q[S_Addr];
        if (t_live) T = regs_q[T_Addr];
        if (!reset && wr_ok && (D_Addr == S_Addr)) S = D;
        if (!reset && wr_ok && (D_Addr == T_Addr)) T = D;
    end

    regfile_scoreboard #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_scoreboard (
        .clk       (clk),
        .reset     (reset),
        .lock_en   (lock_ok),
        .lock_addr (L_Addr),
        .clr_en    (wr_ok),
        .clr_addr  (D_Addr),
        .rd_a_addr (S_Addr),
        .rd_b_addr (T_Addr),
        .rd_a_busy (S_Busy),
        .rd_b_busy (T_Busy)
    );

endmodule

// File: tb/tb_regfile_2r1w_param.sv
// Self-checking bench for regfile_2r1w_param: default 32x32 instance plus a DEPTH=20 instance.
module tb_regfile_2r1w_param;
    import regfile_pkg::*;

    localparam int W = 66;

    typedef struct packed {
        logic        rst;
        logic [4:0]  sa;
        logic [4:0]  ta;
        logic [4:0]  da;
        logic [31:0] dv;
        logic        de;
        logic [4:0]  la;
        logic        le;
    } stim_t;

    logic  clk = 1'b0;
    logic  reset;
    addr_t s_addr, t_addr, d_addr, l_addr;
    word_t d;
    logic  d_en, l_en;
    word_t s, t;
    logic  s_busy, t_busy;

    logic [4:0]  s20, t20, d_addr20, l_addr20;
    logic [31:0] d20;
    logic        d_en20, l_en20;
    logic [31:0] s_o20, t_o20;
    logic        s_busy20, t_busy20;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] exp20_q[$];
    logic [31:0]  mdl32 [32];
    logic [31:0]  mdl20 [32];
    logic         busy32 [32];
    logic         busy20 [32];
    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    regfile_2r1w_param dut (
        .clk(clk), .reset(reset),
        .S_Addr(s_addr), .T_Addr(t_addr), .D_Addr(d_addr), .D(d), .D_En(d_en),
        .L_Addr(l_addr), .L_En(l_en),
        .S(s), .T(t), .S_Busy(s_busy), .T_Busy(t_busy)
    );

    regfile_2r1w_param #(.DEPTH(20)) dut20 (
        .clk(clk), .reset(reset),
        .S_Addr(s20), .T_Addr(t20), .D_Addr(d_addr20), .D(d20), .D_En(d_en20),
        .L_Addr(l_addr20), .L_En(l_en20),
        .S(s_o20), .T(t_o20), .S_Busy(s_busy20), .T_Busy(t_busy20)
    );

    function automatic logic live(input logic [4:0] a, input int depth);
        live = (int'(a) < depth);
`ifdef REGFILE_R0_ZERO_EN
        if (a == 5'd0) live = 1'b0;
`endif
    endfunction

    function automatic logic [W-1:0] model32();
        logic [31:0] es, et;
        logic        bs, bt;
        es = live(s_addr, 32) ? mdl32[s_addr] : 32'h0;
        et = live(t_addr, 32) ? mdl32[t_addr] : 32'h0;
        bs = live(s_addr, 32) ? busy32[s_addr] : 1'b0;
        bt = live(t_addr, 32) ? busy32[t_addr] : 1'b0;
        if (!reset && d_en && live(d_addr, 32) && d_addr == s_addr) es = d;
        if (!reset && d_en && live(d_addr, 32) && d_addr == t_addr) et = d;
        return {es, et, bs, bt};
    endfunction

    function automatic logic [W-1:0] model20();
        logic [31:0] es, et;
        logic        bs, bt;
        es = live(s20, 20) ? mdl20[s20] : 32'h0;
        et = live(t20, 20) ? mdl20[t20] : 32'h0;
        bs = live(s20, 20) ? busy20[s20] : 1'b0;
        bt = live(t20, 20) ? busy20[t20] : 1'b0;
        if (!reset && d_en20 && live(d_addr20, 20) && d_addr20 == s20) es = d20;
        if (!reset && d_en20 && live(d_addr20, 20) && d_addr20 == t20) et = d20;
        return {es, et, bs, bt};
    endfunction

    task automatic drive(input stim_t st);
        reset  = st.rst;
        s_addr = st.sa;
        t_addr = st.ta;
        d_addr = st.da;
        d      = st.dv;
        d_en   = st.de;
        l_addr = st.la;
        l_en   = st.le;
        exp_q.push_back(model32());
    endtask

    task automatic drive20(input stim_t st);
        s20      = st.sa;
        t20      = st.ta;
        d_addr20 = st.da;
        d20      = st.dv;
        d_en20   = st.de;
        l_addr20 = st.la;
        l_en20   = st.le;
        exp20_q.push_back(model20());
    endtask

    // Apply the rising edge to the reference model, then return to the falling edge.
    task automatic advance();
        @(posedge clk);
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                mdl32[i] = '0; busy32[i] = 1'b0;
                mdl20[i] = '0; busy20[i] = 1'b0;
            end
        end else begin
            if (d_en && live(d_addr, 32)) begin
                mdl32[d_addr] = d; busy32[d_addr] = 1'b0;
            end
            if (l_en && live(l_addr, 32)) busy32[l_addr] = 1'b1;
            if (d_en20 && live(d_addr20, 20)) begin
                mdl20[d_addr20] = d20; busy20[d_addr20] = 1'b0;
            end
            if (l_en20 && live(l_addr20, 20)) busy20[l_addr20] = 1'b1;
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        stim_t seq[$];
        logic [W-1:0] got, ev;
        // First reset edge: outputs still unknown, so just clock it in.
        drive('{1'b1, 5'd3, 5'd4, 5'd3, 32'hFFFF_FFFF, 1'b1, 5'd4, 1'b1});
        void'(exp_q.pop_front());
        advance();
        seq.push_back('{1'b1, 5'd3, 5'd4, 5'd3, 32'hFFFF_FFFF, 1'b1, 5'd4, 1'b1});
        for (int i = 0; i < 32; i++)
            seq.push_back('{1'b0, 5'(i), 5'((i + 16) % 32), 5'd0, 32'h0, 1'b0, 5'd0, 1'b0});
        foreach (seq[k]) begin
            drive(seq[k]);
            #2;
            got = {s, t, s_busy, t_busy};
            ev  = exp_q.pop_front();
            n_tests++;
            if (got !== ev) begin
                n_fail++;
                $display("FAIL reset_dump step%0d: got %h, expected %h", k, got, ev);
            end
            advance();
        end
    endtask

    task automatic test_write();
        stim_t seq[$];
        logic [W-1:0] got, ev;
        seq.push_back('{1'b0, 5'd0, 5'd0, 5'd0, 32'hFFFF_FFFF, 1'b1, 5'd0, 1'b0});
        for (int i = 1; i <= 30; i++)
            seq.push_back('{1'b0, 5'($urandom_range(0, 31)), 5'(i), 5'(i),
                            32'hA5A5_0000 + 32'(i), 1'b1, 5'd0, 1'b0});
        for (int i = 0; i < 32; i++)
            seq.push_back('{1'b0, 5'(i), 5'((i + 16) % 32), 5'd0, 32'h0, 1'b0, 5'd0, 1'b0});
        foreach (seq[k]) begin
            drive(seq[k]);
            #2;
            got = {s, t, s_busy, t_busy};
            ev  = exp_q.pop_front();
            n_tests++;
            if (got !== ev) begin
                n_fail++;
                $display("FAIL write_dump step%0d: got %h, expected %h", k, got, ev);
            end
            advance();
        end
    endtask

    task automatic test_bypass();
        stim_t seq[$];
        logic [W-1:0] got, ev;
        seq.push_back('{1'b0, 5'd5, 5'd5, 5'd5, 32'h1234_5678, 1'b1, 5'd0, 1'b0});
        seq.push_back('{1'b1, 5'd5, 5'd5, 5'd5, 32'hCAFE_F00D, 1'b1, 5'd0, 1'b0});
        seq.push_back('{1'b0, 5'd5, 5'd6, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0});
        foreach (seq[k]) begin
            drive(seq[k]);
            #2;
            got = {s, t, s_busy, t_busy};
            ev  = exp_q.pop_front();
            n_tests++;
            if (got !== ev) begin
                n_fail++;
                $display("FAIL bypass step%0d: got %h, expected %h", k, got, ev);
            end
            advance();
        end
        n_tests++;
        if (ev[65:34] !== 32'h0) begin
            n_fail++;
            $display("FAIL bypass_model_clear: model S %h, required 0", ev[65:34]);
        end
    endtask

    task automatic test_lock();
        stim_t seq[$];
        logic [W-1:0] got, ev;
        seq.push_back('{1'b0, 5'd7, 5'd9, 5'd0, 32'h0, 1'b0, 5'd7, 1'b1});
        seq.push_back('{1'b0, 5'd7, 5'd9, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0});
        seq.push_back('{1'b0, 5'd7, 5'd7, 5'd7, 32'h0000_0077, 1'b1, 5'd0, 1'b0});
        seq.push_back('{1'b0, 5'd7, 5'd9, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0});
        seq.push_back('{1'b0, 5'd9, 5'd9, 5'd9, 32'h0000_0099, 1'b1, 5'd9, 1'b1});
        seq.push_back('{1'b0, 5'd7, 5'd9, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0});
        seq.push_back('{1'b0, 5'd0, 5'd0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b1});
        seq.push_back('{1'b0, 5'd0, 5'd9, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0});
        foreach (seq[k]) begin
            drive(seq[k]);
            #2;
            got = {s, t, s_busy, t_busy};
            ev  = exp_q.pop_front();
            n_tests++;
            if (got !== ev) begin
                n_fail++;
                $display("FAIL lock step%0d: got %h, expected %h", k, got, ev);
            end
            advance();
        end
    endtask

    task automatic test_reset_locks();
        stim_t seq[$];
        logic [W-1:0] got, ev;
        seq.push_back('{1'b0, 5'd3, 5'd4, 5'd3, 32'h0000_0033, 1'b1, 5'd0, 1'b0});
        seq.push_back('{1'b0, 5'd3, 5'd4, 5'd4, 32'h0000_0044, 1'b1, 5'd3, 1'b1});
        seq.push_back('{1'b0, 5'd3, 5'd4, 5'd0, 32'h0, 1'b0, 5'd4, 1'b1});
        seq.push_back('{1'b0, 5'd3, 5'd4, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0});
        seq.push_back('{1'b1, 5'd3, 5'd4, 5'd3, 32'h0000_00EE, 1'b1, 5'd3, 1'b1});
        seq.push_back('{1'b0, 5'd3, 5'd4, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0});
        foreach (seq[k]) begin
            drive(seq[k]);
            #2;
            got = {s, t, s_busy, t_busy};
            ev  = exp_q.pop_front();
            n_tests++;
            if (got !== ev) begin
                n_fail++;
                $display("FAIL reset_locks step%0d: got %h, expected %h", k, got, ev);
            end
            advance();
        end
    endtask

    task automatic test_random();
        logic [W-1:0] got, ev;
        stim_t st;
        for (int k = 0; k < 300; k++) begin
            st.rst = ($urandom_range(0, 31) == 0);
            st.sa  = 5'($urandom_range(0, 31));
            st.ta  = ($urandom_range(0, 3) == 0) ? st.sa : 5'($urandom_range(0, 31));
            st.da  = ($urandom_range(0, 2) == 0) ? st.sa : 5'($urandom_range(0, 31));
            st.dv  = $urandom;
            st.de  = 1'($urandom_range(0, 1));
            st.la  = ($urandom_range(0, 3) == 0) ? st.da : 5'($urandom_range(0, 31));
            st.le  = 1'($urandom_range(0, 1));
            drive(st);
            #2;
            got = {s, t, s_busy, t_busy};
            ev  = exp_q.pop_front();
            n_tests++;
            if (got !== ev) begin
                n_fail++;
                $display("FAIL random cyc%0d: got %h, expected %h", k, got, ev);
            end
            advance();
        end
    endtask

    task automatic test_depth20();
        stim_t seq[$];
        logic [W-1:0] got, ev;
        drive('{1'b0, 5'd0, 5'd0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0});
        void'(exp_q.pop_front());
        for (int i = 0; i < 20; i++)
            seq.push_back('{1'b0, 5'(i), 5'd25, 5'(i), 32'h0000_2000 + 32'(i), 1'b1, 5'(i), 1'b0});
        seq.push_back('{1'b0, 5'd25, 5'd25, 5'd25, 32'hDEAD_BEEF, 1'b1, 5'd25, 1'b1});
        seq.push_back('{1'b0, 5'd25, 5'd19, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0});
        for (int i = 0; i < 20; i++)
            seq.push_back('{1'b0, 5'(i), 5'(19 - i), 5'd0, 32'h0, 1'b0, 5'd0, 1'b0});
        foreach (seq[k]) begin
            drive20(seq[k]);
            #2;
            got = {s_o20, t_o20, s_busy20, t_busy20};
            ev  = exp20_q.pop_front();
            n_tests++;
            if (got !== ev) begin
                n_fail++;
                $display("FAIL depth20 step%0d: got %h, expected %h", k, got, ev);
            end
            advance();
        end
    endtask

    initial begin
        reset = 1'b1;
        s_addr = '0; t_addr = '0; d_addr = '0; d = '0; d_en = 1'b0; l_addr = '0; l_en = 1'b0;
        s20 = '0; t20 = '0; d_addr20 = '0; d20 = '0; d_en20 = 1'b0; l_addr20 = '0; l_en20 = 1'b0;
        for (int i = 0; i < 32; i++) begin
            mdl32[i] = '0; busy32[i] = 1'b0;
            mdl20[i] = '0; busy20[i] = 1'b0;
        end
        @(negedge clk);
        test_reset();
        test_write();
        test_bypass();
        test_lock();
        test_reset_locks();
        test_random();
        test_depth20();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
